// File: rtl/execute_memory_stage.sv
// EX->MEM pipeline register: captures Execute results, owns the NZCV flag
// register, annuls condition-failed instructions and counts them.
module execute_memory_stage #(
  parameter int WIDTH = 8,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [REGW-1:0]  WA3E,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlags,
  input  logic             validE,
  input  logic             stallM,
  input  logic             flushM,
  output logic             readyE,
  output logic             CondExE,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REGW-1:0]  WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             validM,
  output logic [3:0]       FlagsQ,
  output logic [7:0]       SquashCount
);

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [REGW-1:0]  wa3_q, wa3_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             valid_q, valid_d;
  logic [3:0]       flags_q, flags_d;
  logic [7:0]       squash_q, squash_d;
  logic             cond_ex;
  logic             flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition evaluation against the architectural flags (no ALUFlags bypass)
  always_comb begin
    cond_ex = 1'b0;
    unique case (CondE)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = ~flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = ~flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = ~flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = ~flag_v;
      4'h8: cond_ex = flag_c & ~flag_z;
      4'h9: cond_ex = ~flag_c | flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
      4'hD: cond_ex = flag_z | (flag_n != flag_v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state: flush beats stall beats load
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    valid_d      = valid_q;
    flags_d      = flags_q;
    squash_d     = squash_q;
    if (flushM) begin
      alu_result_d = '0;
      write_data_d = '0;
      wa3_d        = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      valid_d      = 1'b0;
    end else if (!stallM) begin
      alu_result_d = ALUResultE;
      write_data_d = WriteDataE;
      wa3_d        = WA3E;
      mem_to_reg_d = MemtoRegE;
      valid_d      = validE;
      reg_write_d  = RegWriteE & validE & cond_ex;
      mem_write_d  = MemWriteE & validE & cond_ex;
      if (validE & FlagWriteE & cond_ex) flags_d = ALUFlags;
      if (validE & ~cond_ex & (squash_q != 8'hFF)) squash_d = squash_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      valid_q      <= 1'b0;
      flags_q      <= '0;
      squash_q     <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      valid_q      <= valid_d;
      flags_q      <= flags_d;
      squash_q     <= squash_d;
    end
  end

  assign readyE      = ~stallM;
  assign CondExE     = cond_ex;
  assign ALUResultM  = alu_result_q;
  assign WriteDataM  = write_data_q;
  assign WA3M        = wa3_q;
  assign RegWriteM   = reg_write_q;
  assign MemWriteM   = mem_write_q;
  assign MemtoRegM   = mem_to_reg_q;
  assign validM      = valid_q;
  assign FlagsQ      = flags_q;
  assign SquashCount = squash_q;

endmodule
